// File: rtl/spi_arb_pkg.sv
// spi_arb_pkg
// Shared definitions for the SPI transfer arbiter: FSM state encoding,
// default CS gap / LOAD starvation limit, and the byte width of the
// shared shift engine.
// Ports: none (package).
package spi_arb_pkg;

    localparam int BYTE_W      = 8;
    localparam int CS_GAP_DEF  = 2;
    localparam int TIMEOUT_DEF = 16;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_LOAD  = 3'd2,
        ST_WAIT  = 3'd3,
        ST_GAP   = 3'd4
    } state_t;

endpackage

// File: rtl/spi_xfer_arbiter_if.sv
// spi_xfer_arbiter_if
// Bundles the requester-side byte streams and the shared engine handshake.
// Ports (signals):
//   tx_valid/tx_data/tx_last  requester -> arbiter byte stream (NREQ lanes)
//   tx_ready                  arbiter -> requester byte accept
//   rx_valid/rx_data          arbiter -> requester received byte
//   grant/spi_cs_n/abort      ownership, slave selects, timeout abort pulse
//   eng_start/eng_tx          arbiter -> engine byte launch
//   eng_done/eng_rx           engine -> arbiter completion
// Modports: slave = arbiter side, master = requesters + engine side.
interface spi_xfer_arbiter_if #(
    parameter int NREQ = 2
);
    logic [NREQ-1:0]                      tx_valid;
    logic [spi_arb_pkg::BYTE_W*NREQ-1:0]  tx_data;
    logic [NREQ-1:0]                      tx_last;
    logic [NREQ-1:0]                      tx_ready;
    logic [NREQ-1:0]                      rx_valid;
    logic [spi_arb_pkg::BYTE_W-1:0]       rx_data;
    logic [NREQ-1:0]                      grant;
    logic [NREQ-1:0]                      spi_cs_n;
    logic                                 eng_start;
    logic [spi_arb_pkg::BYTE_W-1:0]       eng_tx;
    logic                                 eng_done;
    logic [spi_arb_pkg::BYTE_W-1:0]       eng_rx;
    logic                                 abort;

    modport slave (
        input  tx_valid, tx_data, tx_last, eng_done, eng_rx,
        output tx_ready, rx_valid, rx_data, grant, spi_cs_n,
               eng_start, eng_tx, abort
    );

    modport master (
        output tx_valid, tx_data, tx_last, eng_done, eng_rx,
        input  tx_ready, rx_valid, rx_data, grant, spi_cs_n,
               eng_start, eng_tx, abort
    );
endinterface

// File: rtl/spi_rr_pick.sv
// spi_rr_pick
// Combinational round-robin selector: picks the first set request at or
// after index (i_last + 1) mod NREQ.
// Ports:
//   i_req   request vector
//   i_last  index of the previous owner
//   o_pick  one-hot selected requester
//   o_idx   index of the selected requester
//   o_any   at least one request is set
module spi_rr_pick #(
    parameter int NREQ = 2
) (
    input  logic [NREQ-1:0]         i_req,
    input  logic [$clog2(NREQ)-1:0] i_last,
    output logic [NREQ-1:0]         o_pick,
    output logic [$clog2(NREQ)-1:0] o_idx,
    output logic                    o_any
);
    localparam int IW = $clog2(NREQ);

    // Scan from the farthest offset down to the nearest so the nearest
    // candidate after i_last is the one left standing.
    always_comb begin
        o_pick = '0;
        o_idx  = '0;
        o_any  = 1'b0;
        for (int k = NREQ; k >= 1; k--) begin
            if (i_req[(int'(i_last) + k) % NREQ]) begin
                o_pick = '0;
                o_pick[(int'(i_last) + k) % NREQ] = 1'b1;
                o_idx  = IW'((int'(i_last) + k) % NREQ);
                o_any  = 1'b1;
            end
        end
    end
endmodule

// File: rtl/spi_xfer_arbiter.sv
// spi_xfer_arbiter
// Shares one byte-level SPI shift engine between NREQ requesters with
// round-robin arbitration at transaction granularity. CS of the owner is
// held low across all bytes of a transaction, then all CS stay high for
// CS_GAP cycles plus one arbitration cycle.
// Ports:
//   ACLK     clock
//   ARESETN  synchronous active-low reset
//   bus      spi_xfer_arbiter_if.slave (requester streams + engine)
// Optional feature: define SPI_ARB_TIMEOUT_EN to abort a transaction whose
// owner leaves LOAD starved for TIMEOUT_CYCLES cycles.
//
// state | meaning
// IDLE  | no owner; arbitrate among tx_valid
// SETUP | owner CS low one cycle before the first byte
// LOAD  | tx_ready to owner, waiting for a byte
// WAIT  | byte on the engine, waiting for eng_done
// GAP   | all CS high for CS_GAP cycles
module spi_xfer_arbiter
    import spi_arb_pkg::*;
#(
    parameter int NREQ           = 2,
    parameter int CS_GAP         = CS_GAP_DEF,
    parameter int TIMEOUT_CYCLES = TIMEOUT_DEF
) (
    input  logic              ACLK,
    input  logic              ARESETN,
    spi_xfer_arbiter_if.slave bus
);
    localparam int            IW       = $clog2(NREQ);
    localparam int            GW       = $clog2(CS_GAP + 1);
    localparam logic [GW-1:0] GAP_LOAD = GW'(CS_GAP - 1);
    localparam logic [IW-1:0] LAST_RST = IW'(NREQ - 1);

    state_t              r_state, w_next;
    logic [NREQ-1:0]     r_grant;
    logic [IW-1:0]       r_last;
    logic                r_last_flag;
    logic [BYTE_W-1:0]   r_eng_tx;
    logic                r_eng_start;
    logic [NREQ-1:0]     r_rx_valid;
    logic [BYTE_W-1:0]   r_rx_data;
    logic [GW-1:0]       r_gap_cnt;

    logic [NREQ-1:0]     w_pick_oh;
    logic [IW-1:0]       w_pick_idx;
    logic                w_pick_any;
    logic [BYTE_W-1:0]   w_byte;
    logic                w_last;
    logic                w_valid_g;
    logic                w_hs;
    logic                w_done;
    logic                w_timeout;

    spi_rr_pick #(.NREQ(NREQ)) u_pick (
        .i_req  (bus.tx_valid),
        .i_last (r_last),
        .o_pick (w_pick_oh),
        .o_idx  (w_pick_idx),
        .o_any  (w_pick_any)
    );

    always_comb begin
        w_byte = '0;
        w_last = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (r_grant[i]) begin
                w_byte = bus.tx_data[BYTE_W*i +: BYTE_W];
                w_last = bus.tx_last[i];
            end
        end
    end

    assign w_valid_g = |(bus.tx_valid & r_grant);
    assign w_hs      = (r_state == ST_LOAD) && w_valid_g;
    // The cycle carrying eng_start cannot also complete the byte.
    assign w_done    = (r_state == ST_WAIT) && bus.eng_done && !r_eng_start;

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (w_pick_any) w_next = ST_SETUP;
            ST_SETUP: w_next = ST_LOAD;
            ST_LOAD: begin
                if (w_hs)           w_next = ST_WAIT;
                else if (w_timeout) w_next = ST_GAP;
            end
            ST_WAIT:  if (w_done) w_next = r_last_flag ? ST_GAP : ST_LOAD;
            ST_GAP:   if (r_gap_cnt == '0) w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            r_state     <= ST_IDLE;
            r_grant     <= '0;
            r_last      <= LAST_RST;
            r_last_flag <= 1'b0;
            r_eng_tx    <= '0;
            r_eng_start <= 1'b0;
            r_rx_valid  <= '0;
            r_rx_data   <= '0;
            r_gap_cnt   <= GAP_LOAD;
        end else begin
            r_state     <= w_next;
            r_eng_start <= w_hs;
            r_rx_valid  <= w_done ? r_grant : '0;
            if (r_state == ST_IDLE && w_pick_any) begin
                r_grant <= w_pick_oh;
                r_last  <= w_pick_idx;
            end else if (w_next == ST_GAP) begin
                r_grant <= '0;
            end
            if (w_hs) begin
                r_eng_tx    <= w_byte;
                r_last_flag <= w_last;
            end
            if (w_done) r_rx_data <= bus.eng_rx;
            if (r_state != ST_GAP)    r_gap_cnt <= GAP_LOAD;
            else if (r_gap_cnt != '0) r_gap_cnt <= r_gap_cnt - GW'(1);
        end
    end

`ifdef SPI_ARB_TIMEOUT_EN
    localparam int            TW      = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TO_LOAD = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] r_to_cnt;
    logic          r_abort;

    // Down-counter reloads outside LOAD and on every accepted byte.
    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            r_to_cnt <= TO_LOAD;
            r_abort  <= 1'b0;
        end else begin
            r_abort <= w_timeout;
            if (r_state != ST_LOAD || w_hs) r_to_cnt <= TO_LOAD;
            else if (r_to_cnt != '0)        r_to_cnt <= r_to_cnt - TW'(1);
        end
    end

    assign w_timeout = (r_state == ST_LOAD) && !w_valid_g && (r_to_cnt == '0);
    assign bus.abort = r_abort;
`else
    assign w_timeout = 1'b0;
    assign bus.abort = 1'b0;
`endif

    assign bus.grant     = r_grant;
    assign bus.tx_ready  = (r_state == ST_LOAD) ? r_grant : '0;
    assign bus.spi_cs_n  = (r_state == ST_SETUP || r_state == ST_LOAD ||
                            r_state == ST_WAIT) ? ~r_grant : '1;
    assign bus.eng_start = r_eng_start;
    assign bus.eng_tx    = r_eng_tx;
    assign bus.rx_valid  = r_rx_valid;
    assign bus.rx_data   = r_rx_data;
endmodule

// File: tb/tb_spi_xfer_arbiter.sv
// tb_spi_xfer_arbiter
// Directed bench for spi_xfer_arbiter (NREQ=2, CS_GAP=2, TIMEOUT_CYCLES=16).
// Inputs are driven and outputs sampled on the falling edge; the engine
// model answers each eng_start with the inverted byte after eng_lat cycles.
// The abort sequence is only present when SPI_ARB_TIMEOUT_EN is defined.
module tb_spi_xfer_arbiter;

    localparam int NREQ = 2;
    localparam int GAP  = 2;

    logic clk;
    logic rst_n;

    spi_xfer_arbiter_if #(.NREQ(NREQ)) bus ();

    spi_xfer_arbiter #(
        .NREQ           (NREQ),
        .CS_GAP         (GAP),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .ACLK    (clk),
        .ARESETN (rst_n),
        .bus     (bus)
    );

    typedef struct {
        int         req;
        int         nbytes;
        logic [7:0] b0;
        logic [7:0] b1;
        int         lat;
        logic [7:0] x0;
        logic [7:0] x1;
    } vec_t;

    vec_t vecs [5];

    int n_checks = 0;
    int n_fail   = 0;
    int inv_err  = 0;
    int cs_break = 0;
    int watch_req = -1;
    int eng_lat  = 2;
    bit eng_auto = 1'b1;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1, "watchdog");
    end

    // Engine model: inverted byte returned eng_lat cycles after eng_start.
    initial begin : engine
        int         pend_cnt;
        logic [7:0] pend_rx;
        pend_cnt = 0;
        pend_rx  = '0;
        bus.eng_done = 1'b0;
        bus.eng_rx   = '0;
        forever begin
            @(negedge clk);
            if (eng_auto) begin
                bus.eng_done = 1'b0;
                if (bus.eng_start === 1'b1) begin
                    pend_rx  = ~bus.eng_tx;
                    pend_cnt = eng_lat;
                end else if (pend_cnt > 0) begin
                    pend_cnt--;
                    if (pend_cnt == 0) begin
                        bus.eng_done = 1'b1;
                        bus.eng_rx   = pend_rx;
                    end
                end
            end
        end
    end

    // Structural invariants: one owner at most, CS mirrors grant, ready only to owner.
    initial begin : monitor
        forever begin
            @(negedge clk);
            if (!$onehot0(bus.grant) || bus.spi_cs_n !== ~bus.grant ||
                (bus.tx_ready & ~bus.grant) !== '0 || !$onehot0(bus.rx_valid))
                inv_err++;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        if (watch_req >= 0 && bus.spi_cs_n[watch_req] !== 1'b0) cs_break++;
        @(negedge clk);
    endtask

    task automatic send_byte(input int req, input logic [7:0] d, input logic lst);
        int n;
        n = 0;
        bus.tx_valid[req]       = 1'b1;
        bus.tx_data[8*req +: 8] = d;
        bus.tx_last[req]        = lst;
        while (bus.tx_ready[req] !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        check("load_ready", 32'(bus.tx_ready[req]), 32'd1);
        tick();
        bus.tx_valid[req] = 1'b0;
        bus.tx_last[req]  = 1'b0;
        check("start_pulse", 32'(bus.eng_start), 32'd1);
        check("eng_tx", 32'(bus.eng_tx), 32'(d));
        check("ready_drop", 32'(bus.tx_ready), 32'd0);
    endtask

    task automatic recv_byte(input int req, input logic [7:0] exp);
        int n;
        n = 0;
        while (bus.rx_valid[req] !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        check("rx_valid", 32'(bus.rx_valid[req]), 32'd1);
        check("rx_data", 32'(bus.rx_data), 32'(exp));
    endtask

    task automatic wait_grant(input int limit);
        int n;
        n = 0;
        while (bus.grant === '0 && n < limit) begin
            tick();
            n++;
        end
    endtask

    task automatic wait_release(input int limit);
        int n;
        n = 0;
        while (bus.grant !== '0 && n < limit) begin
            tick();
            n++;
        end
    endtask

    initial begin : main
        logic [1:0] rr_exp [4];
        int         hi;
        int         n;
        int         rxv_seen;

        vecs[0] = '{0, 2, 8'hA5, 8'h3C, 2, 8'h5A, 8'hC3};
        vecs[1] = '{1, 1, 8'h00, 8'h00, 1, 8'hFF, 8'h00};
        vecs[2] = '{0, 1, 8'hFF, 8'h00, 3, 8'h00, 8'h00};
        vecs[3] = '{1, 2, 8'h81, 8'h7E, 1, 8'h7E, 8'h81};
        vecs[4] = '{0, 2, 8'h0F, 8'hF0, 4, 8'hF0, 8'h0F};
        rr_exp[0] = 2'b01;
        rr_exp[1] = 2'b10;
        rr_exp[2] = 2'b01;
        rr_exp[3] = 2'b10;

        rst_n        = 1'b0;
        bus.tx_valid = '0;
        bus.tx_data  = '0;
        bus.tx_last  = '0;
        repeat (3) @(negedge clk);

        // Reset values
        check("rst_grant", 32'(bus.grant), 32'd0);
        check("rst_cs_n", 32'(bus.spi_cs_n), 32'd3);
        check("rst_tx_ready", 32'(bus.tx_ready), 32'd0);
        check("rst_rx_valid", 32'(bus.rx_valid), 32'd0);
        check("rst_rx_data", 32'(bus.rx_data), 32'd0);
        check("rst_eng_start", 32'(bus.eng_start), 32'd0);
        check("rst_eng_tx", 32'(bus.eng_tx), 32'd0);
        check("rst_abort", 32'(bus.abort), 32'd0);
        rst_n = 1'b1;
        tick();

        // Both request in the same cycle after reset: requester 0 first.
        bus.tx_valid = 2'b11;
        bus.tx_data  = 16'h3412;
        bus.tx_last  = 2'b11;
        tick();
        check("both_first_grant", 32'(bus.grant), 32'd1);
        send_byte(0, 8'h12, 1'b1);
        recv_byte(0, 8'hED);
        hi = 0;
        n  = 0;
        while (bus.grant === '0 && n < 20) begin
            if (bus.spi_cs_n === 2'b11) hi++;
            tick();
            n++;
        end
        // CS_GAP cycles in GAP plus the single IDLE arbitration cycle.
        check("both_cs_high_cycles", 32'(hi), 32'(GAP + 1));
        check("both_second_grant", 32'(bus.grant), 32'd2);
        check("both_second_cs", 32'(bus.spi_cs_n), 32'd1);
        send_byte(1, 8'h34, 1'b1);
        recv_byte(1, 8'hCB);
        repeat (4) tick();

        // Continuous 1-byte requests from both: alternating grants.
        eng_lat      = 1;
        bus.tx_valid = 2'b11;
        bus.tx_data  = 16'h5555;
        bus.tx_last  = 2'b11;
        for (int i = 0; i < 4; i++) begin
            wait_grant(30);
            check("rr_grant", 32'(bus.grant), 32'(rr_exp[i]));
            wait_release(30);
        end
        bus.tx_valid = '0;
        bus.tx_last  = '0;
        repeat (4) tick();

        // Table of single-requester transactions.
        for (int v = 0; v < 5; v++) begin
            eng_lat = vecs[v].lat;
            bus.tx_valid[vecs[v].req]               = 1'b1;
            bus.tx_data[8*vecs[v].req +: 8]         = vecs[v].b0;
            bus.tx_last[vecs[v].req]                = (vecs[v].nbytes == 1);
            tick();
            check("vec_setup_grant", 32'(bus.grant), 32'(2'b01 << vecs[v].req));
            check("vec_setup_ready", 32'(bus.tx_ready), 32'd0);
            cs_break  = 0;
            watch_req = vecs[v].req;
            send_byte(vecs[v].req, vecs[v].b0, vecs[v].nbytes == 1);
            recv_byte(vecs[v].req, vecs[v].x0);
            if (vecs[v].nbytes == 2) begin
                send_byte(vecs[v].req, vecs[v].b1, 1'b1);
                recv_byte(vecs[v].req, vecs[v].x1);
            end
            watch_req = -1;
            check("vec_cs_held", 32'(cs_break), 32'd0);
            check("vec_end_cs", 32'(bus.spi_cs_n), 32'd3);
            check("vec_end_grant", 32'(bus.grant), 32'd0);
            repeat (4) tick();
        end

        // Reset while WAIT; late eng_done must not produce rx_valid.
        eng_auto = 1'b0;
        eng_lat  = 2;
        tick();
        bus.tx_valid[0] = 1'b1;
        tick();
        send_byte(0, 8'h11, 1'b0);
        tick();
        rst_n = 1'b0;
        tick();
        check("wrst_cs_n", 32'(bus.spi_cs_n), 32'd3);
        check("wrst_grant", 32'(bus.grant), 32'd0);
        check("wrst_eng_start", 32'(bus.eng_start), 32'd0);
        check("wrst_eng_tx", 32'(bus.eng_tx), 32'd0);
        rst_n = 1'b1;
        bus.eng_done = 1'b1;
        bus.eng_rx   = 8'h77;
        tick();
        bus.eng_done = 1'b0;
        rxv_seen = 0;
        repeat (3) begin
            tick();
            if (bus.rx_valid !== '0) rxv_seen++;
        end
        check("wrst_no_rx_valid", 32'(rxv_seen), 32'd0);
        check("wrst_rx_data", 32'(bus.rx_data), 32'd0);
        eng_auto = 1'b1;
        tick();

`ifdef SPI_ARB_TIMEOUT_EN
        // Requester 0 stalls after a non-last byte; requester 1 is waiting.
        bus.tx_valid = 2'b11;
        bus.tx_data  = 16'h4422;
        bus.tx_last  = 2'b10;
        tick();
        check("to_grant0", 32'(bus.grant), 32'd1);
        send_byte(0, 8'h22, 1'b0);
        recv_byte(0, 8'hDD);
        n = 0;
        while (bus.abort !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        check("to_abort", 32'(bus.abort), 32'd1);
        check("to_abort_delay", 32'(n), 32'd16);
        check("to_cs_release", 32'(bus.spi_cs_n), 32'd3);
        tick();
        check("to_abort_pulse", 32'(bus.abort), 32'd0);
        wait_grant(20);
        check("to_next_grant", 32'(bus.grant), 32'd2);
        send_byte(1, 8'h44, 1'b1);
        recv_byte(1, 8'hBB);
        repeat (4) tick();
`endif

        // Handshake timing: eng_start one cycle only, eng_tx stable to eng_done.
        eng_lat = 4;
        bus.tx_valid[1]   = 1'b1;
        bus.tx_data[15:8] = 8'h96;
        bus.tx_last[1]    = 1'b1;
        tick();
        send_byte(1, 8'h96, 1'b1);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("hs_start_low", 32'(bus.eng_start), 32'd0);
            check("hs_eng_tx_hold", 32'(bus.eng_tx), 32'h96);
        end
        recv_byte(1, 8'h69);
        tick();
        check("hs_rx_pulse", 32'(bus.rx_valid), 32'd0);
        repeat (4) tick();

        check("invariants", 32'(inv_err), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
